// File: rtl/vm_if.sv
// vm_if: bundle between the vending controller and its coin, button, dispenser and panel side.
// The refund request line exists only when VM_REFUND_EN is defined.
interface vm_if #(parameter int CREDIT_W = 3);
  logic coin, coffee, sprite, disp_done;
  logic disp_req, disp_sel, coin_reject, coin_return, led_coffee, led_sprite, busy, fault;
  logic [CREDIT_W-1:0] credit;
`ifdef VM_REFUND_EN
  logic refund;
  modport master(output coin, coffee, sprite, disp_done, refund,
                 input disp_req, disp_sel, coin_reject, coin_return, credit, led_coffee, led_sprite, busy, fault);
  modport slave(input coin, coffee, sprite, disp_done, refund,
                output disp_req, disp_sel, coin_reject, coin_return, credit, led_coffee, led_sprite, busy, fault);
`else
  modport master(output coin, coffee, sprite, disp_done,
                 input disp_req, disp_sel, coin_reject, coin_return, credit, led_coffee, led_sprite, busy, fault);
  modport slave(input coin, coffee, sprite, disp_done,
                output disp_req, disp_sel, coin_reject, coin_return, credit, led_coffee, led_sprite, busy, fault);
`endif
endinterface

// File: rtl/vm_dispense_arbiter.sv
// vm_dispense_arbiter: coin credit, round-robin coffee/sprite dispense with timeout fault.
// Define VM_REFUND_EN to add the refund request and the coin-return pulse train.
module vm_dispense_arbiter #(
  parameter int CREDIT_W = 3,
  parameter int MAX_CREDIT = 7,
  parameter int PRICE_COFFEE = 1,
  parameter int PRICE_SPRITE = 3,
  parameter int DISP_TIMEOUT = 15,
  parameter int RET_GAP = 2
) (
  input logic clk,
  input logic rst,
  vm_if.slave bus
);
  localparam int TW = $clog2(DISP_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GRANT, FAULT, REFUND} state_t;
  state_t state, state_nx;
  logic [CREDIT_W-1:0] credit, credit_nx, base, pc, ps;
  logic [TW-1:0] tcnt;
  logic sel, rr, reject, coin_ret, vc, vs, go, pick, done, timeout, take, refund_go, ret;
  assign pc = CREDIT_W'(PRICE_COFFEE);
  assign ps = CREDIT_W'(PRICE_SPRITE);
`ifdef VM_REFUND_EN
  localparam bit REF_EN = 1'b1;
  localparam int GW = $clog2(RET_GAP + 2);
  logic [GW-1:0] gap;
  assign refund_go = state == IDLE && bus.refund && credit != '0;
  assign ret = state == REFUND && gap == '0;
  always_ff @(posedge clk)
    gap <= (rst || state != REFUND) ? '0 : (ret ? GW'(RET_GAP) : gap - 1'b1);
`else
  localparam bit REF_EN = 1'b0;
  assign refund_go = 1'b0;
  assign ret = 1'b0;
`endif
  assign vc = bus.coffee && credit >= pc;
  assign vs = bus.sprite && credit >= ps;
  assign go = state == IDLE && (vc || vs) && !refund_go;
  assign pick = (vc && vs) ? rr : vs;
  assign done = state == GRANT && bus.disp_done;
  assign timeout = state == GRANT && !bus.disp_done && tcnt == TW'(DISP_TIMEOUT - 1);
  // a coin arriving with the completing dispense is judged against the post-deduction credit
  assign base = done ? credit - (sel ? ps : pc) : (ret ? credit - 1'b1 : credit);
  assign take = bus.coin && (state == IDLE || state == GRANT) && base < CREDIT_W'(MAX_CREDIT);
  assign credit_nx = base + CREDIT_W'(take);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = refund_go ? REFUND : (go ? GRANT : IDLE);
      GRANT: state_nx = done ? IDLE : (timeout ? FAULT : GRANT);
      FAULT: state_nx = FAULT;
      REFUND: state_nx = (!REF_EN || credit_nx == '0) ? IDLE : REFUND;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      credit <= '0;
      tcnt <= '0;
      sel <= 1'b0;
      rr <= 1'b0;
      reject <= 1'b0;
      coin_ret <= 1'b0;
    end else begin
      state <= state_nx;
      credit <= credit_nx;
      tcnt <= state == GRANT ? tcnt + 1'b1 : '0;
      sel <= go ? pick : sel;
      rr <= go ? !pick : rr;
      reject <= bus.coin && !take;
      coin_ret <= ret;
    end
  end
  assign bus.disp_req = state == GRANT;
  assign bus.disp_sel = sel;
  assign bus.coin_reject = reject;
  assign bus.coin_return = coin_ret;
  assign bus.credit = credit;
  assign bus.led_coffee = state == IDLE && credit >= pc;
  assign bus.led_sprite = state == IDLE && credit >= ps;
  assign bus.busy = state != IDLE;
  assign bus.fault = state == FAULT;
endmodule

// File: tb/tb_vm_dispense_arbiter.sv
// tb_vm_dispense_arbiter: vector table, hand-written corner sequences and a randomized run
// against a behavioural model of the vending controller.
module tb_vm_dispense_arbiter;
  localparam int PC = 1, PS = 3, MAXC = 7, TO = 15, GAP = 2;
`ifdef VM_REFUND_EN
  localparam bit REF = 1'b1;
`else
  localparam bit REF = 1'b0;
`endif
  logic clk = 1'b0, rst;
  int tests = 0, fails = 0;
  vm_if #(.CREDIT_W(3)) bus ();
  vm_dispense_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int m_cr = 0, m_mode = 0, m_t = 0;
  bit m_prod = 0, m_pref = 0, m_rej = 0, m_ret = 0;

  // mode: 0 idle, 1 dispensing, 2 fault, 3 refunding
  task automatic model(input bit r, c, cf, sp, dn, rf);
    int cr;
    bit acc, vc, vs;
    cr = m_cr;
    acc = m_mode < 2;
    m_rej = 0;
    m_ret = 0;
    if (r) begin
      m_cr = 0; m_mode = 0; m_prod = 0; m_pref = 0; m_t = 0;
      return;
    end
    vc = cf && cr >= PC;
    vs = sp && cr >= PS;
    if (m_mode == 0) begin
      if (REF && rf && cr > 0) begin m_mode = 3; m_t = 0; end
      else if (vc || vs) begin
        m_prod = (vc && vs) ? m_pref : vs;
        m_pref = !m_prod;
        m_mode = 1;
        m_t = 0;
      end
    end else if (m_mode == 1) begin
      m_t++;
      if (dn) begin cr -= m_prod ? PS : PC; m_mode = 0; end
      else if (m_t == TO) m_mode = 2;
    end else if (m_mode == 3) begin
      if (m_t % (GAP + 1) == 0) begin
        cr--;
        m_ret = 1;
        if (cr == 0) m_mode = 0;
      end
      m_t++;
    end
    if (c) begin
      if (acc && cr < MAXC) cr++;
      else m_rej = 1;
    end
    m_cr = cr;
  endtask

  function automatic logic [10:0] dut_out();
    return {bus.disp_req, bus.disp_sel, bus.coin_reject, bus.coin_return, bus.credit,
            bus.led_coffee, bus.led_sprite, bus.busy, bus.fault};
  endfunction

  function automatic logic [10:0] model_out();
    return {m_mode == 1, m_prod, m_rej, m_ret, 3'(m_cr), m_mode == 0 && m_cr >= PC,
            m_mode == 0 && m_cr >= PS, m_mode != 0, m_mode == 2};
  endfunction

  task automatic check(input string name, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, c, cf, sp, dn, rf);
    rst = r; bus.coin = c; bus.coffee = cf; bus.sprite = sp; bus.disp_done = dn;
`ifdef VM_REFUND_EN
    bus.refund = rf;
`endif
    model(r, c, cf, sp, dn, rf);
    @(posedge clk);
    #1;
    rst = 0; bus.coin = 0; bus.coffee = 0; bus.sprite = 0; bus.disp_done = 0;
`ifdef VM_REFUND_EN
    bus.refund = 0;
`endif
  endtask

  typedef struct packed {
    logic r, c, cf, sp, dn;
    logic [2:0] cr;
    logic req, sel, rej, busy, ls;
  } vec_t;
  vec_t tbl[21];

  initial begin
    logic [9:0] pulses;
    bit any;
    bit stall;
    tbl[0]  = '{1,0,0,0,0, 3'd0, 0,0,0,0,0};
    tbl[1]  = '{0,1,0,0,0, 3'd1, 0,0,0,0,0};
    tbl[2]  = '{0,1,0,0,0, 3'd2, 0,0,0,0,0};
    tbl[3]  = '{0,1,0,0,0, 3'd3, 0,0,0,0,1};
    tbl[4]  = '{0,0,1,1,0, 3'd3, 1,0,0,1,0};
    tbl[5]  = '{0,0,0,0,1, 3'd2, 0,0,0,0,0};
    tbl[6]  = '{0,1,0,0,0, 3'd3, 0,0,0,0,1};
    tbl[7]  = '{0,0,1,1,0, 3'd3, 1,1,0,1,0};
    tbl[8]  = '{0,0,0,0,1, 3'd0, 0,1,0,0,0};
    tbl[9]  = '{0,1,0,0,0, 3'd1, 0,1,0,0,0};
    tbl[10] = '{0,1,0,0,0, 3'd2, 0,1,0,0,0};
    tbl[11] = '{0,0,0,1,0, 3'd2, 0,1,0,0,0};
    tbl[12] = '{0,1,0,0,0, 3'd3, 0,1,0,0,1};
    tbl[13] = '{0,0,1,0,0, 3'd3, 1,0,0,1,0};
    tbl[14] = '{0,1,0,0,1, 3'd3, 0,0,0,0,1};
    tbl[15] = '{0,1,0,0,0, 3'd4, 0,0,0,0,1};
    tbl[16] = '{0,1,0,0,0, 3'd5, 0,0,0,0,1};
    tbl[17] = '{0,1,0,0,0, 3'd6, 0,0,0,0,1};
    tbl[18] = '{0,1,0,0,0, 3'd7, 0,0,0,0,1};
    tbl[19] = '{0,1,0,0,0, 3'd7, 0,0,1,0,1};
    tbl[20] = '{0,0,0,0,0, 3'd7, 0,0,0,0,1};
    rst = 1; bus.coin = 0; bus.coffee = 0; bus.sprite = 0; bus.disp_done = 0;
`ifdef VM_REFUND_EN
    bus.refund = 0;
`endif
    @(posedge clk);
    #1;
    check("reset_all_outputs", 32'(dut_out()), 32'd0);
    for (int i = 0; i < 21; i++) begin
      step(tbl[i].r, tbl[i].c, tbl[i].cf, tbl[i].sp, tbl[i].dn, 0);
      check($sformatf("vec%0d", i),
            32'({bus.credit, bus.disp_req, bus.disp_sel, bus.coin_reject, bus.busy, bus.led_sprite}),
            32'({tbl[i].cr, tbl[i].req, tbl[i].sel, tbl[i].rej, tbl[i].busy, tbl[i].ls}));
    end
    // dispense timeout: fault exactly on the 15th GRANT cycle without done
    step(1,0,0,0,0,0);
    step(0,1,0,0,0,0);
    step(0,0,1,0,0,0);
    for (int i = 0; i < 15; i++) begin
      step(0,0,0,0,0,0);
      if (i == 13) check("fault_not_early", 32'(bus.fault), 32'd0);
    end
    check("fault_set", 32'({bus.fault, bus.busy, bus.disp_req}), 32'b110);
    check("fault_credit_kept", 32'(bus.credit), 32'd1);
    step(0,1,0,0,0,0);
    check("fault_coin_reject", 32'({bus.coin_reject, bus.credit}), 32'({1'b1, 3'd1}));
    step(0,0,0,0,1,0);
    check("fault_sticky", 32'(bus.fault), 32'd1);
`ifdef VM_REFUND_EN
    step(1,0,0,0,0,0);
    for (int i = 0; i < 3; i++) step(0,1,0,0,0,0);
    step(0,0,1,0,0,1);
    check("refund_wins", 32'({bus.disp_req, bus.busy, bus.credit}), 32'({1'b0, 1'b1, 3'd3}));
    for (int i = 0; i < 10; i++) begin
      step(0,0,0,0,0,0);
      pulses[i] = bus.coin_return;
    end
    check("refund_pulse_train", 32'(pulses), 32'b0001001001);
    check("refund_done", 32'({bus.credit, bus.busy}), 32'd0);
    step(1,0,0,0,0,0);
    for (int i = 0; i < 3; i++) step(0,1,0,0,0,0);
    step(0,0,0,0,0,1);
    step(0,0,0,0,0,0);
    check("refund_first_pulse", 32'({bus.coin_return, bus.credit}), 32'({1'b1, 3'd2}));
    step(1,0,0,0,0,0);
    check("rst_mid_refund", 32'({bus.coin_return, bus.credit, bus.busy}), 32'd0);
    any = 0;
    for (int i = 0; i < 6; i++) begin
      step(0,0,0,0,0,0);
      any |= bus.coin_return;
    end
    check("no_pulse_after_rst", 32'(any), 32'd0);
`endif
    // randomized run against the model
    step(1,0,0,0,0,0);
    stall = 0;
    for (int i = 0; i < 4000; i++) begin
      bit r;
      if ($urandom_range(0, 59) == 0) stall = !stall;
      r = ($urandom_range(0, 199) == 0) || (m_mode == 2 && $urandom_range(0, 7) == 0);
      step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           !stall && $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      check("random_vs_model", 32'(dut_out()), 32'(model_out()));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
